// File: rtl/l2_arbiter_pkg.sv
// Shared types for the L2 port arbiter.
//   arb_state_t : controller state (idle, I-cache granted, D-cache granted)
//   arb_grant_t : which requester wins the next grant
package arb_types;

  typedef enum logic [1:0] {ARB_IDLE, ARB_I, ARB_D} arb_state_t;

  typedef enum logic {GRANT_I, GRANT_D} arb_grant_t;

endpackage

// File: rtl/l2_arbiter_if.sv
// Bundle of every signal around the L2 arbiter: the I-cache side, the D-cache side and the
// single downstream memory port.
//   slave  : arbiter view (takes cache requests and the pmem response, drives pmem strobes)
//   master : environment view (caches plus downstream memory)
// Parameters: ADDR_W byte address width, LINE_W cache-line width.
interface l2_arbiter_if #(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned LINE_W = 256
);

  logic              i_read;
  logic [ADDR_W-1:0] i_address;
  logic [LINE_W-1:0] i_rdata;
  logic              i_resp;

  logic              d_read;
  logic              d_write;
  logic [ADDR_W-1:0] d_address;
  logic [LINE_W-1:0] d_wdata;
  logic [LINE_W-1:0] d_rdata;
  logic              d_resp;

  logic              pmem_read;
  logic              pmem_write;
  logic [ADDR_W-1:0] pmem_address;
  logic [LINE_W-1:0] pmem_wdata;
  logic [LINE_W-1:0] pmem_rdata;
  logic              pmem_resp;

  modport slave (
    input  i_read, i_address, d_read, d_write, d_address, d_wdata, pmem_rdata, pmem_resp,
    output i_rdata, i_resp, d_rdata, d_resp, pmem_read, pmem_write, pmem_address, pmem_wdata
  );

  modport master (
    output i_read, i_address, d_read, d_write, d_address, d_wdata, pmem_rdata, pmem_resp,
    input  i_rdata, i_resp, d_rdata, d_resp, pmem_read, pmem_write, pmem_address, pmem_wdata
  );

endinterface

// File: rtl/l2_arbiter_arb_pick.sv
// Grant policy for the L2 arbiter. Purely combinational.
//   i_req, d_req : pending requests from the I- and D-cache
//   last_grant   : side granted most recently (consulted only in round-robin builds)
//   grant        : side to grant next; meaningful only when a request is pending
// Macro L2_ARB_RR_EN selects round-robin; otherwise the D side always wins a tie, because an
// outstanding D-miss stalls every pipeline stage.
module arb_pick
  import arb_types::*;
(
  input  logic       i_req,
  input  logic       d_req,
  input  arb_grant_t last_grant,
  output arb_grant_t grant
);

  always_comb begin
    grant = GRANT_I;
    if (d_req && !i_req) begin
      grant = GRANT_D;
    end else if (d_req && i_req) begin
`ifdef L2_ARB_RR_EN
      grant = (last_grant == GRANT_I) ? GRANT_D : GRANT_I;
`else
      grant = GRANT_D;
`endif
    end
  end

`ifndef L2_ARB_RR_EN
  // Fixed priority ignores history.
  logic unused_last_grant;
  assign unused_last_grant = last_grant;
`endif

endmodule

// File: rtl/l2_arbiter.sv
// Shares the single L2/physical memory port between the L1 I-cache and D-cache. One line
// transaction is granted at a time; the downstream response is forwarded only to the granted
// side. All pmem outputs are combinational from the state register and the held requests.
//   clk   : clock
//   rst_n : synchronous active-low reset
//   bus   : l2_arbiter_if slave modport (cache sides and downstream port)
// Macro L2_ARB_RR_EN: round-robin tie-break with a last_grant register; undefined gives fixed
// D-side priority and no last_grant register.
module l2_arbiter
  import arb_types::*;
(
  input logic         clk,
  input logic         rst_n,
  l2_arbiter_if.slave bus
);

  arb_state_t state_q, state_d;
  arb_grant_t grant;
  arb_grant_t last_grant;
  logic       i_req, d_req;

  assign i_req = bus.i_read;
  assign d_req = bus.d_read | bus.d_write;

  arb_pick u_pick (
    .i_req      (i_req),
    .d_req      (d_req),
    .last_grant (last_grant),
    .grant      (grant)
  );

`ifdef L2_ARB_RR_EN
  arb_grant_t last_grant_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      last_grant_q <= GRANT_I;
    end else if (state_q == ARB_IDLE && (i_req || d_req)) begin
      last_grant_q <= grant;
    end
  end

  assign last_grant = last_grant_q;
`else
  assign last_grant = GRANT_I;
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= ARB_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d          = state_q;
    bus.pmem_read    = 1'b0;
    bus.pmem_write   = 1'b0;
    bus.pmem_address = '0;
    bus.pmem_wdata   = bus.d_wdata;  // only meaningful for D writes
    bus.i_resp       = 1'b0;
    bus.d_resp       = 1'b0;
    unique case (state_q)
      ARB_IDLE: begin
        // A pmem_resp here is stray and deliberately dropped.
        if (i_req || d_req) begin
          state_d = (grant == GRANT_D) ? ARB_D : ARB_I;
        end
      end
      ARB_I: begin
        bus.pmem_read    = bus.i_read;
        bus.pmem_address = bus.i_address;
        bus.i_resp       = bus.pmem_resp;
        if (bus.pmem_resp) state_d = ARB_IDLE;
      end
      ARB_D: begin
        // Read and write together is illegal; the write wins.
        bus.pmem_read    = bus.d_read & ~bus.d_write;
        bus.pmem_write   = bus.d_write;
        bus.pmem_address = bus.d_address;
        bus.i_resp       = 1'b0;
        bus.d_resp       = bus.pmem_resp;
        if (bus.pmem_resp) state_d = ARB_IDLE;
      end
      default: state_d = ARB_IDLE;
    endcase
  end

  // Each requester qualifies the shared read data with its own resp.
  assign bus.i_rdata = bus.pmem_rdata;
  assign bus.d_rdata = bus.pmem_rdata;

endmodule

// File: tb/tb_l2_arbiter.sv
// Self-checking bench for l2_arbiter: directed scenarios followed by randomized rounds. Expected
// transactions are queued at issue time and checked by a monitor when pmem_resp completes them.
module tb_l2_arbiter;
  import arb_types::*;

  localparam int unsigned AW = 32;
  localparam int unsigned LW = 256;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  l2_arbiter_if #(.ADDR_W(AW), .LINE_W(LW)) bus ();

  l2_arbiter dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit            is_d;
    bit            rd;
    bit            wr;
    logic [AW-1:0] addr;
    logic [LW-1:0] wdata;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   passes = 0;

  // Reference model of the grant policy: remembers the last side granted (1 = D).
  bit model_lg_d = 1'b0;

  function automatic bit pick_d(bit ri, bit rd);
    if (ri && rd) begin
`ifdef L2_ARB_RR_EN
      return !model_lg_d;
`else
      return 1'b1;
`endif
    end
    return rd;
  endfunction

  task automatic check(string name, logic [LW-1:0] act, logic [LW-1:0] req);
    checks++;
    if (act === req) passes++;
    else $display("FAIL %s: got %h want %h", name, act, req);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [LW-1:0] rand_line();
    logic [LW-1:0] v;
    for (int k = 0; k < 8; k++) v[k*32 +: 32] = $urandom;
    return v;
  endfunction

  // Downstream memory model: responds after a random latency when enabled.
  bit          auto_resp = 1'b0;
  bit          busy = 1'b0;
  int unsigned cnt = 0;

  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (auto_resp) begin
        bus.pmem_resp = 1'b0;
        if (busy) begin
          if (cnt == 0) begin
            bus.pmem_resp  = 1'b1;
            bus.pmem_rdata = rand_line();
            busy = 1'b0;
          end else begin
            cnt--;
          end
        end
      end
      @(negedge clk);
      if (auto_resp && rst_n && !busy && !bus.pmem_resp && (bus.pmem_read || bus.pmem_write)) begin
        busy = 1'b1;
        cnt  = $urandom_range(0, 4);
      end
    end
  end

  // Monitor: completes queued transactions and polices responses everywhere else.
  always @(negedge clk) begin : monitor
    exp_t e;
    if (rst_n) begin
      assert (!(bus.d_read && bus.d_write)) else $error("illegal d_read and d_write together");
      if (bus.pmem_resp && (bus.pmem_read || bus.pmem_write)) begin
        check("txn_expected", LW'(exp_q.size() > 0), 1);
        if (exp_q.size() > 0) begin
          e = exp_q.pop_front();
          check("txn_read", bus.pmem_read, e.rd);
          check("txn_write", bus.pmem_write, e.wr);
          check("txn_addr", bus.pmem_address, e.addr);
          if (e.is_d) check("txn_wdata", bus.pmem_wdata, e.wdata);
          check("txn_i_resp", bus.i_resp, !e.is_d);
          check("txn_d_resp", bus.d_resp, e.is_d);
          check("txn_rdata", e.is_d ? bus.d_rdata : bus.i_rdata, bus.pmem_rdata);
        end
      end else begin
        check("no_resp", {bus.i_resp, bus.d_resp}, 2'b00);
      end
    end
  end

  task automatic push_exp(bit is_d, bit rd, bit wr, logic [AW-1:0] a, logic [LW-1:0] w);
    exp_t e;
    e.is_d = is_d; e.rd = rd; e.wr = wr; e.addr = a; e.wdata = w;
    exp_q.push_back(e);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    bus.i_read = 1'b0; bus.i_address = '0;
    bus.d_read = 1'b0; bus.d_write = 1'b0; bus.d_address = '0; bus.d_wdata = '0;
    bus.pmem_resp = 1'b0; bus.pmem_rdata = '0;
    busy = 1'b0;
    exp_q.delete();
    tick();
    tick();
    rst_n = 1'b1;
    model_lg_d = 1'b0;
  endtask

  task automatic pulse_resp(logic [LW-1:0] data);
    tick();
    bus.pmem_resp  = 1'b1;
    bus.pmem_rdata = data;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

  initial begin
    logic [AW-1:0] ai, ad;
    logic [LW-1:0] wd;
    bit            first_d;

    do_reset();
    @(negedge clk);
    check("rst_pmem_read", bus.pmem_read, 0);
    check("rst_pmem_write", bus.pmem_write, 0);
    check("rst_resps", {bus.i_resp, bus.d_resp}, 2'b00);

    // Three simultaneous pairs starting from reset.
    for (int p = 0; p < 3; p++) begin
      ai = 32'h0000_2000 + 32'(p * 64);
      ad = 32'h0000_4000 + 32'(p * 64);
      wd = rand_line();
      tick();
      bus.i_read = 1'b1; bus.i_address = ai;
      bus.d_read = 1'b1; bus.d_address = ad; bus.d_wdata = wd;
      first_d = pick_d(1'b1, 1'b1);
      model_lg_d = !first_d;
      push_exp(first_d, 1'b1, 1'b0, first_d ? ad : ai, wd);
      push_exp(!first_d, 1'b1, 1'b0, first_d ? ai : ad, wd);
      tick();
      @(negedge clk);
      check("sim_first_addr", bus.pmem_address, first_d ? ad : ai);
      check("sim_first_read", bus.pmem_read, 1);
      tick();
      @(negedge clk);
      check("sim_held_resp", {bus.i_resp, bus.d_resp}, 2'b00);
      pulse_resp(rand_line());
      @(negedge clk);
      tick();
      bus.pmem_resp = 1'b0;
      if (first_d) bus.d_read = 1'b0;
      else bus.i_read = 1'b0;
      @(negedge clk);
      check("sim_turn_idle", bus.pmem_read, 0);
      tick();
      @(negedge clk);
      check("sim_second_addr", bus.pmem_address, first_d ? ai : ad);
      check("sim_second_read", bus.pmem_read, 1);
      pulse_resp(rand_line());
      tick();
      bus.pmem_resp = 1'b0;
      bus.i_read = 1'b0;
      bus.d_read = 1'b0;
    end

    // I-cache line read with a five-cycle downstream latency.
    tick();
    bus.i_read = 1'b1; bus.i_address = 32'h0000_0060;
    model_lg_d = 1'b0;
    push_exp(1'b0, 1'b1, 1'b0, 32'h0000_0060, '0);
    @(negedge clk);
    check("i_lat_before", bus.pmem_read, 0);
    tick();
    @(negedge clk);
    check("i_lat_read", bus.pmem_read, 1);
    check("i_lat_addr", bus.pmem_address, 32'h0000_0060);
    check("i_lat_write", bus.pmem_write, 0);
    repeat (3) tick();
    pulse_resp({8{32'hDEADBEEF}});
    @(negedge clk);
    check("i_resp_pulse", bus.i_resp, 1);
    check("i_rdata", bus.i_rdata, {8{32'hDEADBEEF}});
    check("i_no_d_resp", bus.d_resp, 0);
    tick();
    bus.pmem_resp = 1'b0;
    bus.i_read = 1'b0;
    @(negedge clk);
    check("i_resp_width", bus.i_resp, 0);

    // D-cache writeback.
    tick();
    bus.d_write = 1'b1; bus.d_address = 32'h0000_1000; bus.d_wdata = {8{32'h12345678}};
    model_lg_d = 1'b1;
    push_exp(1'b1, 1'b0, 1'b1, 32'h0000_1000, {8{32'h12345678}});
    for (int k = 0; k < 3; k++) begin
      tick();
      @(negedge clk);
      check("d_wr_write", bus.pmem_write, 1);
      check("d_wr_read", bus.pmem_read, 0);
      check("d_wr_addr", bus.pmem_address, 32'h0000_1000);
      check("d_wr_wdata", bus.pmem_wdata, {8{32'h12345678}});
    end
    pulse_resp(rand_line());
    @(negedge clk);
    check("d_wr_resp", bus.d_resp, 1);
    check("d_wr_read_end", bus.pmem_read, 0);
    tick();
    bus.pmem_resp = 1'b0;
    bus.d_write = 1'b0;
    @(negedge clk);
    check("d_wr_resp_width", bus.d_resp, 0);
    check("d_wr_idle", bus.pmem_write, 0);

    // Reset while the D side holds the port.
    tick();
    bus.d_write = 1'b1; bus.d_address = 32'h0000_3000;
    tick();
    @(negedge clk);
    check("rst_mid_granted", bus.pmem_write, 1);
    tick();
    rst_n = 1'b0;
    bus.d_write = 1'b0;
    tick();
    rst_n = 1'b1;
    model_lg_d = 1'b0;
    @(negedge clk);
    check("rst_mid_strobes", {bus.pmem_read, bus.pmem_write}, 2'b00);
    pulse_resp(rand_line());
    @(negedge clk);
    check("rst_mid_no_resp", {bus.i_resp, bus.d_resp}, 2'b00);
    tick();
    bus.pmem_resp = 1'b0;

    // Stray response in idle.
    pulse_resp(rand_line());
    @(negedge clk);
    check("stray_resps", {bus.i_resp, bus.d_resp}, 2'b00);
    tick();
    bus.pmem_resp = 1'b0;
    @(negedge clk);
    check("stray_stays_idle", {bus.pmem_read, bus.pmem_write}, 2'b00);

    // Randomized rounds against the policy model.
    auto_resp = 1'b1;
    for (int r = 0; r < 60; r++) begin
      bit ri, rd, dw, pend_i, pend_d, gi, gd;
      int budget;
      ri = 1'($urandom_range(0, 1));
      rd = 1'($urandom_range(0, 1));
      if (!ri && !rd) ri = 1'b1;
      dw = 1'($urandom_range(0, 1));
      ai = $urandom & 32'hFFFF_FFE0;
      ad = $urandom & 32'hFFFF_FFE0;
      wd = rand_line();
      first_d = pick_d(ri, rd);
      push_exp(first_d, first_d ? !dw : 1'b1, first_d ? dw : 1'b0, first_d ? ad : ai, wd);
      model_lg_d = first_d;
      if (ri && rd) begin
        push_exp(!first_d, !first_d ? !dw : 1'b1, !first_d ? dw : 1'b0, !first_d ? ad : ai, wd);
        model_lg_d = !first_d;
      end
      bus.i_read = ri; bus.i_address = ai;
      bus.d_read = rd & !dw; bus.d_write = rd & dw; bus.d_address = ad; bus.d_wdata = wd;
      pend_i = ri; pend_d = rd; budget = 0;
      while ((pend_i || pend_d) && budget < 200) begin
        @(negedge clk);
        gi = bus.i_resp;
        gd = bus.d_resp;
        tick();
        if (gi) begin pend_i = 1'b0; bus.i_read = 1'b0; end
        if (gd) begin pend_d = 1'b0; bus.d_read = 1'b0; bus.d_write = 1'b0; end
        budget++;
      end
      check("round_done", {pend_i, pend_d}, 2'b00);
      if (pend_i || pend_d) do_reset();
      repeat ($urandom_range(0, 2)) tick();
    end
    auto_resp = 1'b0;
    tick();
    check("queue_drained", exp_q.size(), 0);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
